// File: rtl/sram_access_arbiter.sv
// Arbitrates the quad-SPI SRAM command port between the audio datapath and the host register
// path, one word transaction at a time, with host anti-starvation and a completion timeout.
module sram_access_arbiter #(
  parameter int unsigned ADDR_W        = 17,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned HOST_MAX_WAIT = 4,
  parameter int unsigned TIMEOUT_CYC   = 1024
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              aud_req_i,
  input  logic              aud_we_i,
  input  logic [ADDR_W-1:0] aud_addr_i,
  input  logic [DATA_W-1:0] aud_wdata_i,
  output logic              aud_ack_o,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_ack_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              resp_err_o,
  output logic              mem_start_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_busy_i,
  input  logic              mem_done_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              timeout_flag_o,
  input  logic              clear_flag_i,
  output logic              busy_o
);

  localparam int unsigned StarveW = $clog2(HOST_MAX_WAIT + 1);
  localparam int unsigned TmoW    = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic                owner_host_q, owner_host_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                resp_err_q, resp_err_d;
  logic                timeout_flag_q, timeout_flag_d;
  logic [StarveW-1:0]  starve_cnt_q, starve_cnt_d;
  logic [TmoW-1:0]     tmo_cnt_q, tmo_cnt_d;

  logic grant;
  logic host_win;
  logic tmo_hit;

  assign grant    = (aud_req_i | host_req_i) & ~mem_busy_i;
  assign host_win = host_req_i & (~aud_req_i | (starve_cnt_q == StarveW'(HOST_MAX_WAIT)));
  // Abort one cycle after the counter reaches TIMEOUT_CYC-1, so the ack lands
  // TIMEOUT_CYC+2 cycles after mem_start.
  assign tmo_hit  = (tmo_cnt_q == TmoW'(TIMEOUT_CYC));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= StIdle;
      owner_host_q   <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      rd_data_q      <= '0;
      resp_err_q     <= 1'b0;
      timeout_flag_q <= 1'b0;
      starve_cnt_q   <= '0;
      tmo_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      owner_host_q   <= owner_host_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      rd_data_q      <= rd_data_d;
      resp_err_q     <= resp_err_d;
      timeout_flag_q <= timeout_flag_d;
      starve_cnt_q   <= starve_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (mem_done_i || tmo_hit) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    owner_host_d   = owner_host_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    rd_data_d      = rd_data_q;
    resp_err_d     = resp_err_q;
    starve_cnt_d   = starve_cnt_q;
    tmo_cnt_d      = tmo_cnt_q;
    // A set in the same cycle as clear_flag wins.
    timeout_flag_d = timeout_flag_q & ~clear_flag_i;
    unique case (state_q)
      StIdle: begin
        if (!host_req_i) starve_cnt_d = '0;
        if (grant) begin
          owner_host_d = host_win;
          tmo_cnt_d    = '0;
          if (host_win) begin
            mem_we_d     = host_we_i;
            mem_addr_d   = host_addr_i;
            mem_wdata_d  = host_wdata_i;
            starve_cnt_d = '0;
          end else begin
            mem_we_d    = aud_we_i;
            mem_addr_d  = aud_addr_i;
            mem_wdata_d = aud_wdata_i;
            if (host_req_i && (starve_cnt_q != StarveW'(HOST_MAX_WAIT))) begin
              starve_cnt_d = starve_cnt_q + StarveW'(1);
            end
          end
        end
      end
      StWait: begin
        if (mem_done_i) begin
          if (!mem_we_q) rd_data_d = mem_rdata_i;
          resp_err_d = 1'b0;
        end else if (tmo_hit) begin
          rd_data_d      = '0;
          resp_err_d     = 1'b1;
          timeout_flag_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_start_o = (state_q == StIssue);
    aud_ack_o   = (state_q == StResp) & ~owner_host_q;
    host_ack_o  = (state_q == StResp) & owner_host_q;
    busy_o      = (state_q != StIdle);
  end

  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign rd_data_o      = rd_data_q;
  assign resp_err_o     = resp_err_q;
  assign timeout_flag_o = timeout_flag_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Self-checking bench for sram_access_arbiter: directed scenarios plus a randomized run
// checked against a request-level model of priority, starvation and latency.
module tb_sram_access_arbiter;

  localparam int unsigned TMO = 64;
  localparam int unsigned HMW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        aud_req = 1'b0, aud_we = 1'b0, host_req = 1'b0, host_we = 1'b0;
  logic [16:0] aud_addr = '0, host_addr = '0;
  logic [15:0] aud_wdata = '0, host_wdata = '0;
  logic        aud_ack, host_ack, resp_err, mem_start, mem_we, timeout_flag, busy;
  logic [15:0] rd_data, mem_wdata;
  logic [16:0] mem_addr;
  logic        mem_busy = 1'b0, mem_done = 1'b0, clear_flag = 1'b0;
  logic [15:0] mem_rdata = '0;

  int total = 0;
  int passed = 0;
  logic [16:0] prev_addr;

  sram_access_arbiter #(
    .ADDR_W(17), .DATA_W(16), .HOST_MAX_WAIT(HMW), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .aud_req_i(aud_req), .aud_we_i(aud_we), .aud_addr_i(aud_addr), .aud_wdata_i(aud_wdata),
    .aud_ack_o(aud_ack),
    .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata), .host_ack_o(host_ack),
    .rd_data_o(rd_data), .resp_err_o(resp_err),
    .mem_start_o(mem_start), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_busy_i(mem_busy), .mem_done_i(mem_done), .mem_rdata_i(mem_rdata),
    .timeout_flag_o(timeout_flag), .clear_flag_i(clear_flag), .busy_o(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total++;
    if ({aud_ack, host_ack, mem_start, resp_err, timeout_flag, busy, mem_we} !== 7'b0)
      $display("FAIL reset_ctrl: got %b, expected 0000000",
               {aud_ack, host_ack, mem_start, resp_err, timeout_flag, busy, mem_we});
    else passed++;
    total++;
    if ({mem_addr, mem_wdata, rd_data} !== '0)
      $display("FAIL reset_fields: got %h/%h/%h, expected 0/0/0", mem_addr, mem_wdata, rd_data);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    int hacks = 0;
    aud_req = 1'b1; aud_we = 1'b0; aud_addr = 17'h00123;
    step();
    total++;
    if ({mem_start, mem_we, mem_addr} !== {1'b1, 1'b0, 17'h00123})
      $display("FAIL single_issue: got start=%b we=%b addr=%h, expected 1 0 00123",
               mem_start, mem_we, mem_addr);
    else passed++;
    step();
    total++;
    if (mem_start !== 1'b0) $display("FAIL single_start_width: got %b, expected 0", mem_start);
    else passed++;
    repeat (4) begin
      step();
      if (host_ack || aud_ack) hacks++;
    end
    mem_done = 1'b1; mem_rdata = 16'hBEEF;
    step();
    mem_done = 1'b0;
    total++;
    if ({aud_ack, host_ack, resp_err, rd_data} !== {3'b100, 16'hBEEF} || hacks != 0)
      $display("FAIL single_ack: got aud=%b host=%b err=%b rd=%h early=%0d, expected 1 0 0 beef 0",
               aud_ack, host_ack, resp_err, rd_data, hacks);
    else passed++;
    aud_req = 1'b0;
    step();
    total++;
    if ({busy, aud_ack} !== 2'b00) $display("FAIL single_idle: got %b, expected 00", {busy, aud_ack});
    else passed++;
  endtask

  task automatic test_contention();
    int streak = 0;
    int n;
    logic exp_h;
    aud_req = 1'b1; aud_we = 1'b0; aud_addr = 17'h00AAA;
    host_req = 1'b1; host_we = 1'b0; host_addr = 17'h00555;
    for (int g = 0; g < 10; g++) begin
      n = 0;
      do begin step(); n++; end while (mem_start !== 1'b1 && n < 20);
      exp_h = (streak == HMW);
      if (exp_h) streak = 0; else streak++;
      total++;
      if (mem_start !== 1'b1 || mem_addr !== (exp_h ? host_addr : aud_addr))
        $display("FAIL contention_grant%0d: got start=%b addr=%h, expected 1 %h", g, mem_start,
                 mem_addr, exp_h ? host_addr : aud_addr);
      else passed++;
      step();
      step();
      mem_done = 1'b1; mem_rdata = 16'(g);
      step();
      mem_done = 1'b0;
      total++;
      if ({aud_ack, host_ack} !== (exp_h ? 2'b01 : 2'b10))
        $display("FAIL contention_ack%0d: got %b, expected %b", g, {aud_ack, host_ack},
                 exp_h ? 2'b01 : 2'b10);
      else passed++;
    end
    aud_req = 1'b0; host_req = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int n;
    int spurious = 0;
    host_we = 1'b1; host_addr = 17'h1FFFF; host_wdata = 16'h5A5A; host_req = 1'b1;
    n = 0;
    do begin step(); n++; end while (mem_start !== 1'b1 && n < 10);
    total++;
    if ({mem_start, mem_we, mem_addr, mem_wdata} !== {2'b11, 17'h1FFFF, 16'h5A5A})
      $display("FAIL tmo_issue: got %b %b %h %h, expected 1 1 1ffff 5a5a", mem_start, mem_we,
               mem_addr, mem_wdata);
    else passed++;
    n = 0;
    do begin step(); n++; end while (host_ack !== 1'b1 && aud_ack !== 1'b1 && n < TMO + 10);
    total++;
    if (host_ack !== 1'b1 || n != TMO + 2)
      $display("FAIL tmo_latency: got ack=%b after %0d cycles, expected 1 after %0d", host_ack, n,
               TMO + 2);
    else passed++;
    total++;
    if ({resp_err, timeout_flag, rd_data} !== {2'b11, 16'h0000})
      $display("FAIL tmo_resp: got err=%b flag=%b rd=%h, expected 1 1 0000", resp_err,
               timeout_flag, rd_data);
    else passed++;
    host_req = 1'b0;
    step();
    mem_done = 1'b1; mem_rdata = 16'hDEAD;
    step();
    mem_done = 1'b0;
    repeat (6) begin
      if (aud_ack || host_ack || mem_start || busy) spurious++;
      step();
    end
    total++;
    if (spurious != 0 || timeout_flag !== 1'b1)
      $display("FAIL tmo_late_done: got spurious=%0d flag=%b, expected 0 1", spurious, timeout_flag);
    else passed++;
    clear_flag = 1'b1;
    step();
    clear_flag = 1'b0;
    total++;
    if (timeout_flag !== 1'b0) $display("FAIL tmo_clear: got %b, expected 0", timeout_flag);
    else passed++;
    // Second timeout with clear held: the set must win on its own cycle.
    aud_req = 1'b1; aud_we = 1'b0; aud_addr = 17'h00777; clear_flag = 1'b1;
    n = 0;
    do begin step(); n++; end while (aud_ack !== 1'b1 && n < TMO + 20);
    total++;
    if ({aud_ack, resp_err, timeout_flag} !== 3'b111)
      $display("FAIL tmo_set_vs_clear: got ack=%b err=%b flag=%b, expected 1 1 1", aud_ack,
               resp_err, timeout_flag);
    else passed++;
    aud_req = 1'b0;
    step();
    clear_flag = 1'b0;
    total++;
    if (timeout_flag !== 1'b0) $display("FAIL tmo_clear_after: got %b, expected 0", timeout_flag);
    else passed++;
    prev_addr = 17'h00777;
  endtask

  task automatic test_busy_stall();
    int starts = 0;
    mem_busy = 1'b1;
    aud_req = 1'b1; aud_we = 1'b1; aud_addr = 17'h0ABCD; aud_wdata = 16'hC0DE;
    repeat (10) begin
      step();
      if (mem_start || busy) starts++;
    end
    total++;
    if (starts != 0 || mem_addr !== prev_addr)
      $display("FAIL stall_hold: got starts=%0d addr=%h, expected 0 %h", starts, mem_addr,
               prev_addr);
    else passed++;
    mem_busy = 1'b0;
    step();
    total++;
    if ({mem_start, mem_we, mem_addr, mem_wdata} !== {2'b11, 17'h0ABCD, 16'hC0DE})
      $display("FAIL stall_release: got %b %b %h %h, expected 1 1 0abcd c0de", mem_start, mem_we,
               mem_addr, mem_wdata);
    else passed++;
    step();
    mem_done = 1'b1; mem_rdata = 16'hFFFF;
    step();
    mem_done = 1'b0;
    total++;
    if ({aud_ack, resp_err, rd_data} !== {2'b10, 16'h0000})
      $display("FAIL stall_write_ack: got ack=%b err=%b rd=%h, expected 1 0 0000", aud_ack,
               resp_err, rd_data);
    else passed++;
    aud_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_wait();
    int n;
    int spurious = 0;
    aud_req = 1'b1; aud_we = 1'b0; aud_addr = 17'h00042;
    n = 0;
    do begin step(); n++; end while (mem_start !== 1'b1 && n < 10);
    step();
    step();
    reset = 1'b1; aud_req = 1'b0;
    step();
    reset = 1'b0;
    mem_done = 1'b1; mem_rdata = 16'h1111;
    step();
    mem_done = 1'b0;
    total++;
    if ({aud_ack, host_ack, mem_start, resp_err, timeout_flag, busy, mem_we} !== 7'b0 ||
        {mem_addr, mem_wdata, rd_data} !== '0)
      $display("FAIL rst_mid_wait: got ctrl=%b addr=%h rd=%h, expected 0000000 0 0",
               {aud_ack, host_ack, mem_start, resp_err, timeout_flag, busy, mem_we}, mem_addr,
               rd_data);
    else passed++;
    repeat (4) begin
      step();
      if (aud_ack || host_ack || busy) spurious++;
    end
    total++;
    if (spurious != 0) $display("FAIL rst_no_ack: got %0d, expected 0", spurious);
    else passed++;
    aud_req = 1'b1;
    n = 0;
    do begin step(); n++; end while (mem_start !== 1'b1 && n < 10);
    step();
    mem_done = 1'b1; mem_rdata = 16'h2468;
    step();
    mem_done = 1'b0;
    total++;
    if ({aud_ack, rd_data} !== {1'b1, 16'h2468})
      $display("FAIL rst_recover: got ack=%b rd=%h, expected 1 2468", aud_ack, rd_data);
    else passed++;
    aud_req = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int n, t = 0, prev_t = 0, d, prev_d = 0, acks = 0, starts = 0, extra;
    logic [15:0] rdv;
    for (int k = 0; k < 20; k++) begin
      aud_addr = 17'($urandom_range(0, 17'h1FFFF)); aud_we = 1'b0; aud_req = 1'b1;
      n = 0;
      do begin step(); t++; n++; end while (mem_start !== 1'b1 && n < 10);
      if (mem_start) starts++;
      total++;
      if (mem_start !== 1'b1 || mem_addr !== aud_addr)
        $display("FAIL b2b_grant%0d: got start=%b addr=%h, expected 1 %h", k, mem_start, mem_addr,
                 aud_addr);
      else passed++;
      if (k > 0) begin
        total++;
        if (t - prev_t != prev_d + 3)
          $display("FAIL b2b_gap%0d: got %0d, expected %0d", k, t - prev_t, prev_d + 3);
        else passed++;
      end
      prev_t = t;
      d = $urandom_range(1, 4);
      prev_d = d;
      rdv = 16'($urandom);
      extra = 0;
      repeat (d) begin
        step(); t++;
        if (mem_start || aud_ack) extra++;
      end
      mem_done = 1'b1; mem_rdata = rdv;
      step(); t++;
      mem_done = 1'b0;
      if (aud_ack) acks++;
      total++;
      if (aud_ack !== 1'b1 || rd_data !== rdv || extra != 0)
        $display("FAIL b2b_ack%0d: got ack=%b rd=%h extra=%0d, expected 1 %h 0", k, aud_ack,
                 rd_data, extra, rdv);
      else passed++;
      aud_req = 1'b0;
      step(); t++;
    end
    total++;
    if (acks != 20 || starts != 20)
      $display("FAIL b2b_count: got acks=%0d starts=%0d, expected 20 20", acks, starts);
    else passed++;
  endtask

  // Request-level model: arbiter free/busy, who wins, when the ack is due, what SRAM holds.
  task automatic test_random();
    logic [15:0] mem_m [int];
    logic        exp_start = 1'b0, exp_ack = 1'b0, exp_start_n, exp_ack_n;
    logic        free = 1'b1, in_flight = 1'b0, g_host = 1'b0, g_we = 1'b0, exp_rd_valid = 1'b0;
    logic [16:0] g_addr = '0;
    logic [15:0] g_wdata = '0, exp_rd = '0;
    int          streak = 0, done_at = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      total++;
      if (mem_start !== exp_start)
        $display("FAIL rnd_start@%0d: got %b, expected %b", cyc, mem_start, exp_start);
      else passed++;
      if (exp_start) begin
        total++;
        if ({mem_we, mem_addr, mem_wdata} !== {g_we, g_addr, g_wdata})
          $display("FAIL rnd_fields@%0d: got %b %h %h, expected %b %h %h", cyc, mem_we, mem_addr,
                   mem_wdata, g_we, g_addr, g_wdata);
        else passed++;
      end
      total++;
      if ({aud_ack, host_ack} !== {exp_ack & ~g_host, exp_ack & g_host})
        $display("FAIL rnd_ack@%0d: got %b, expected %b", cyc, {aud_ack, host_ack},
                 {exp_ack & ~g_host, exp_ack & g_host});
      else passed++;
      if (exp_ack && exp_rd_valid) begin
        total++;
        if ({resp_err, rd_data} !== {1'b0, exp_rd})
          $display("FAIL rnd_data@%0d: got err=%b rd=%h, expected 0 %h", cyc, resp_err, rd_data,
                   exp_rd);
        else passed++;
      end
      exp_start_n = 1'b0;
      exp_ack_n   = 1'b0;
      mem_done    = 1'b0;
      mem_rdata   = 16'($urandom);
      if (exp_start) begin
        done_at = cyc + $urandom_range(1, 5);
        if ($urandom_range(0, 3) == 0) mem_done = 1'b1;
      end else if (in_flight && !exp_ack && cyc == done_at) begin
        mem_done  = 1'b1;
        exp_ack_n = 1'b1;
        if (g_we) mem_m[int'(g_addr)] = g_wdata;
        else begin
          mem_rdata    = mem_m.exists(int'(g_addr)) ? mem_m[int'(g_addr)] : ~g_addr[15:0];
          exp_rd       = mem_rdata;
          exp_rd_valid = 1'b1;
        end
      end
      if (exp_ack) begin
        in_flight = 1'b0;
        if (g_host) host_req = 1'b0; else aud_req = 1'b0;
      end
      if (cyc < 600 && !aud_req && !(exp_ack && !g_host) && $urandom_range(0, 2) == 0) begin
        aud_req = 1'b1; aud_we = 1'($urandom); aud_addr = 17'($urandom_range(0, 31));
        aud_wdata = 16'($urandom);
      end
      if (cyc < 600 && !host_req && !(exp_ack && g_host) && $urandom_range(0, 2) == 0) begin
        host_req = 1'b1; host_we = 1'($urandom); host_addr = 17'($urandom_range(0, 31));
        host_wdata = 16'($urandom);
      end
      mem_busy = ($urandom_range(0, 3) == 0);
      if (free) begin
        if (!host_req) streak = 0;
        if ((aud_req || host_req) && !mem_busy) begin
          g_host = host_req && (!aud_req || streak == HMW);
          g_we    = g_host ? host_we : aud_we;
          g_addr  = g_host ? host_addr : aud_addr;
          g_wdata = g_host ? host_wdata : aud_wdata;
          if (g_host) streak = 0;
          else if (host_req && streak < HMW) streak++;
          exp_start_n = 1'b1;
          in_flight   = 1'b1;
          free        = 1'b0;
        end
      end
      if (exp_ack) free = 1'b1;
      exp_start = exp_start_n;
      exp_ack   = exp_ack_n;
      if (cyc >= 600 && free && !aud_req && !host_req && !exp_start) break;
    end
    mem_busy = 1'b0;
    mem_done = 1'b0;
    step();
    total++;
    if ({busy, aud_req, host_req} !== 3'b000)
      $display("FAIL rnd_drain: got busy=%b reqs=%b%b, expected 0 00", busy, aud_req, host_req);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_timeout();
    test_busy_stall();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sram_access_arbiter.md
# sram_access_arbiter

Arbitrates the single external quad-SPI SRAM command port between two requesters: the audio datapath (delay/FIR sample buffer, real-time, high priority) and the host register path (SPI-register-driven peek/poke). It sits between those requesters and the SRAM serial interface. It serializes one word transaction at a time, enforces a host anti-starvation limit, and guards every transaction with a completion timeout.

## Interface
Parameters:
- ADDR_W, 17, SRAM word address width
- DATA_W, 16, data word width
- HOST_MAX_WAIT, 4, consecutive audio grants allowed while host_req is pending before host is forced to win
- TIMEOUT_CYC, 1024, WAIT cycles without mem_done before a transaction is aborted

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high
- aud_req  in  1  audio request; level, held until aud_ack
- aud_we  in  1  1 = write, 0 = read; stable while aud_req is high
- aud_addr  in  ADDR_W  audio address
- aud_wdata  in  DATA_W  audio write data
- aud_ack  out  1  one-cycle completion pulse
- host_req, host_we, host_addr, host_wdata, host_ack  same as the aud_* ports, for the host requester
- rd_data  out  DATA_W  read result; valid with either ack, held until the next ack
- resp_err  out  1  valid with an ack; 1 = transaction timed out
- mem_start  out  1  one-cycle command strobe to the SRAM interface
- mem_we, mem_addr, mem_wdata  out  1/ADDR_W/DATA_W  command fields; held from ISSUE through WAIT
- mem_busy  in  1  SRAM interface cannot accept a command
- mem_done  in  1  one-cycle completion pulse from the SRAM interface
- mem_rdata  in  DATA_W  read data, valid with mem_done
- timeout_flag  out  1  sticky; set on any timeout
- clear_flag  in  1  clears timeout_flag
- busy  out  1  high in any state other than IDLE

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and RESP.
- IDLE: if (aud_req | host_req) & !mem_busy, choose a winner, register its we/addr/wdata into the mem_* registers, record the owner, and go to ISSUE. Otherwise stay in IDLE.
- Priority: audio wins, unless host_req is high and starve_cnt == HOST_MAX_WAIT; then host wins.
- starve_cnt:
  - increments (saturating) on every audio grant while host_req = 1
  - clears on a host grant
  - clears when host_req = 0 in IDLE
- ISSUE: mem_start = 1 for exactly one cycle, then go to WAIT. A mem_done seen in ISSUE is ignored.
- WAIT: tmo_cnt counts up from 0.
  - On mem_done: capture mem_rdata into rd_data (read) or leave rd_data unchanged (write); resp_err = 0; go to RESP.
  - If tmo_cnt reaches TIMEOUT_CYC-1 without mem_done: rd_data = 0, resp_err = 1, set timeout_flag, go to RESP.
- RESP: pulse the owner's ack for one cycle, then go to IDLE. The non-owner ack stays 0.
- Requester rule: drop req on the clock edge at which ack = 1 is sampled. A req still high in the following IDLE cycle is treated as a new transaction.
- timeout_flag: a set in the same cycle as clear_flag wins (the flag stays 1).
- A mem_done arriving in IDLE or RESP (a late completion after a timeout) is ignored.

## Timing
- Reset values: state IDLE; aud_ack, host_ack, mem_start, resp_err, timeout_flag and busy all 0; mem_* fields, rd_data, starve_cnt and tmo_cnt all 0.
- Reset mid-transaction: return to IDLE next cycle, drop the in-flight transaction, issue no ack. Requesters must reissue.
- Latency, with req high in cycle 0 (IDLE, mem_busy = 0):
  - cycle 1: ISSUE, mem_start = 1
  - cycle 2: first WAIT cycle
  - mem_done in cycle k ≥ 2 gives ack in cycle k+1
  - minimum req-to-ack is 3 cycles
- Back-to-back throughput: at most one transaction per 4 cycles plus SRAM time (there is an IDLE cycle between transactions).
- Simultaneous aud_req and host_req in IDLE follow the priority rule. The loser's req stays pending with no loss.
- mem_busy high in IDLE stalls arbitration; no fields are latched until mem_busy falls.
- Timeout ack: lands TIMEOUT_CYC+2 cycles after mem_start.

## Test plan
- Single audio read: aud_req, addr 0x00123; mem_done with mem_rdata 0xBEEF 5 cycles after mem_start -> mem_addr 0x00123 and mem_we 0 at mem_start; aud_ack 1 cycle after mem_done; rd_data 0xBEEF; resp_err 0; host_ack stays 0.
- Contention: aud_req and host_req both held continuously, mem_done 2 cycles after every mem_start -> grant order A,A,A,A,H,A,A,A,A,H; starve_cnt returns to 0 after each host grant.
- Timeout: host write 0x5A5A to addr 0x1FFFF, mem_done never asserted -> host_ack with resp_err 1 exactly TIMEOUT_CYC+2 cycles after mem_start; timeout_flag 1 until clear_flag; a mem_done injected later causes no ack.
- mem_busy stall: mem_busy high for 10 cycles while aud_req is high -> no mem_start during the stall; mem_start 1 cycle after mem_busy falls.
- Reset mid-WAIT: reset for 1 cycle during WAIT, then mem_done -> no ack; state IDLE; all outputs at reset values; next aud_req completes normally.
- Back-to-back audio: aud_req re-raised in the cycle after aud_ack, 20 transactions -> 20 acks, each preceded by exactly one mem_start, no lost or duplicated grants.
